// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: sample strobe, data bit, counter clear and match status.
interface seq_detect_param_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output en, x, cnt_clr, input y, match_cnt, cnt_sat);
  modport slave  (input en, x, cnt_clr, output y, match_cnt, cnt_sat);
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern recogniser: masked compare of the last PAT_W bits, optional
// overlap, registered match flag and saturating match counter.
module seq_detect_param #(
  parameter int             PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1011,
  parameter logic [PAT_W-1:0] PAT_MASK = 4'b1111,
  parameter bit             OVERLAP  = 1'b1,
  parameter int             CNT_W    = 8
) (
  input logic              clk,
  input logic              clr_n,
  seq_detect_param_if.slave bus
);

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_width
    $error("seq_detect_param: PAT_W must be in 2..16");
  end
  if (PAT_MASK == '0) begin : g_bad_mask
    $error("seq_detect_param: PAT_MASK must enable at least one bit");
  end

  localparam int FW = $clog2(PAT_W + 1);

  // Only PAT_W-1 past bits are stored; the current x completes the compare window.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] window;
  logic [FW-1:0]    fill, fill_n;
  logic             hit;
  logic             y_q;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             sat;

  always_comb begin
    window  = {hist, bus.x};
    fill_n  = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    hit     = bus.en && (fill_n == FW'(PAT_W)) && (((window ^ PATTERN) & PAT_MASK) == '0);
    cnt_inc = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist <= '0;
      fill <= '0;
      y_q  <= 1'b0;
      cnt  <= '0;
      sat  <= 1'b0;
    end else begin
      if (bus.en) begin
        hist <= window[PAT_W-2:0];
        fill <= (hit && !OVERLAP) ? '0 : fill_n;
      end
      y_q <= hit;
      if (bus.cnt_clr) begin
        cnt <= hit ? CNT_W'(1) : '0;
        sat <= hit && (CNT_W == 1);
      end else if (hit && (cnt != '1)) begin
        cnt <= cnt_inc;
        if (cnt_inc == '1) sat <= 1'b1;
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.match_cnt = cnt;
  assign bus.cnt_sat   = sat;

endmodule

// File: tb/tb_seq_detect_param.sv
// Five seq_detect_param configurations driven in parallel and checked against a queue-based model.
module tb_seq_detect_param;

  localparam int NCFG = 5;
  localparam logic [3:0] PAT [NCFG] = '{4'b1011, 4'b1011, 4'b0000, 4'b1011, 4'b1011};
  localparam logic [3:0] MSK [NCFG] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1101};
  localparam bit         OVL [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam int         CW  [NCFG] = '{8, 8, 8, 2, 8};

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic en = 1'b0, x = 1'b0, cnt_clr = 1'b0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.CNT_W(8)) if0 ();
  seq_detect_param_if #(.CNT_W(8)) if1 ();
  seq_detect_param_if #(.CNT_W(8)) if2 ();
  seq_detect_param_if #(.CNT_W(2)) if3 ();
  seq_detect_param_if #(.CNT_W(8)) if4 ();

  assign if0.en = en; assign if0.x = x; assign if0.cnt_clr = cnt_clr;
  assign if1.en = en; assign if1.x = x; assign if1.cnt_clr = cnt_clr;
  assign if2.en = en; assign if2.x = x; assign if2.cnt_clr = cnt_clr;
  assign if3.en = en; assign if3.x = x; assign if3.cnt_clr = cnt_clr;
  assign if4.en = en; assign if4.x = x; assign if4.cnt_clr = cnt_clr;

  seq_detect_param u0 (.clk(clk), .clr_n(clr_n), .bus(if0));
  seq_detect_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .clr_n(clr_n), .bus(if1));
  seq_detect_param #(.PATTERN(4'b0000)) u2 (.clk(clk), .clr_n(clr_n), .bus(if2));
  seq_detect_param #(.CNT_W(2)) u3 (.clk(clk), .clr_n(clr_n), .bus(if3));
  seq_detect_param #(.PAT_MASK(4'b1101)) u4 (.clk(clk), .clr_n(clr_n), .bus(if4));

  logic        y_a   [NCFG];
  logic [31:0] cnt_a [NCFG];
  logic        sat_a [NCFG];

  assign y_a[0] = if0.y; assign cnt_a[0] = 32'(if0.match_cnt); assign sat_a[0] = if0.cnt_sat;
  assign y_a[1] = if1.y; assign cnt_a[1] = 32'(if1.match_cnt); assign sat_a[1] = if1.cnt_sat;
  assign y_a[2] = if2.y; assign cnt_a[2] = 32'(if2.match_cnt); assign sat_a[2] = if2.cnt_sat;
  assign y_a[3] = if3.y; assign cnt_a[3] = 32'(if3.match_cnt); assign sat_a[3] = if3.cnt_sat;
  assign y_a[4] = if4.y; assign cnt_a[4] = 32'(if4.match_cnt); assign sat_a[4] = if4.cnt_sat;

  // Reference: bits received since reset/restart, most recent last.
  bit hq [NCFG][$];
  bit m_y   [NCFG];
  int m_cnt [NCFG];
  bit m_sat [NCFG];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      hq[k].delete();
      m_y[k] = 1'b0; m_cnt[k] = 0; m_sat[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit e, input bit xb, input bit c);
    for (int k = 0; k < NCFG; k++) begin
      bit hit = 1'b0;
      int maxv = (1 << CW[k]) - 1;
      logic [3:0] val = '0;
      if (e) begin
        hq[k].push_back(xb);
        if (hq[k].size() > 4) void'(hq[k].pop_front());
        if (hq[k].size() == 4) begin
          for (int i = 0; i < 4; i++) val = {val[2:0], hq[k][i]};
          hit = (((val ^ PAT[k]) & MSK[k]) == 4'b0000);
          if (hit && !OVL[k]) hq[k].delete();
        end
      end
      m_y[k] = hit;
      if (c) begin
        m_cnt[k] = hit ? 1 : 0;
        m_sat[k] = (m_cnt[k] == maxv);
      end else begin
        if (hit && m_cnt[k] < maxv) m_cnt[k]++;
        if (m_cnt[k] == maxv) m_sat[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("%s.y%0d", tag, k), 32'(y_a[k]), 32'(m_y[k]));
      check($sformatf("%s.cnt%0d", tag, k), cnt_a[k], 32'(m_cnt[k]));
      check($sformatf("%s.sat%0d", tag, k), 32'(sat_a[k]), 32'(m_sat[k]));
    end
  endtask

  task automatic step(input bit e, input bit xb, input bit c, input string tag);
    en = e; x = xb; cnt_clr = c;
    @(posedge clk);
    model_edge(e, xb, c);
    #1 check_all(tag);
  endtask

  // Called 1 time unit after a posedge (or at time 0); releases before the next edge.
  task automatic do_reset(input string tag);
    clr_n = 1'b0;
    model_reset();
    #2 check_all(tag);
    #1 clr_n = 1'b1;
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input string tag);
    logic [15:0] b = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], 1'b0, tag);
  endtask

  initial begin
    do_reset("rst0");

    feed(16'b1011, 4, "t1");
    check("t1.y_hit", 32'(y_a[0]), 32'd1);
    check("t1.cnt", cnt_a[0], 32'd1);
    step(1'b0, 1'b0, 1'b0, "t1b");
    check("t1.y_drop", 32'(y_a[0]), 32'd0);

    do_reset("rst2");
    feed(16'b1011011, 7, "t2");
    check("t2.cnt_ovl", cnt_a[0], 32'd2);
    check("t2.cnt_novl", cnt_a[1], 32'd1);

    do_reset("rst3");
    feed(16'b10, 2, "t3a");
    for (int i = 0; i < 5; i++) step(1'b0, i[0], 1'b0, "t3gap");
    feed(16'b11, 2, "t3b");
    check("t3.y", 32'(y_a[0]), 32'd1);
    check("t3.cnt", cnt_a[0], 32'd1);

    do_reset("rst4");
    feed(16'b000, 3, "t4a");
    check("t4.y_early", 32'(y_a[2]), 32'd0);
    feed(16'b0, 1, "t4b");
    check("t4.y_zero", 32'(y_a[2]), 32'd1);
    feed(16'b101, 3, "t4c");
    do_reset("t4rst");
    feed(16'b1, 1, "t4d");
    check("t4.y_postrst", 32'(y_a[0]), 32'd0);

    do_reset("rst5");
    feed(16'b1011011011011, 13, "t5a");
    check("t5.cnt_sat", cnt_a[3], 32'd3);
    check("t5.sat", 32'(sat_a[3]), 32'd1);
    step(1'b1, 1'b0, 1'b0, "t5b");
    step(1'b1, 1'b1, 1'b0, "t5b");
    step(1'b1, 1'b1, 1'b1, "t5c");
    check("t5.cnt_clrhit", cnt_a[3], 32'd1);
    check("t5.sat_clrhit", 32'(sat_a[3]), 32'd0);

    do_reset("rst6");
    feed(16'b1001, 4, "t6a");
    check("t6.mask_hit", 32'(y_a[4]), 32'd1);
    do_reset("rst6b");
    feed(16'b0011, 4, "t6b");
    check("t6.mask_miss", 32'(y_a[4]), 32'd0);

    do_reset("rst7");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 47) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
